// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by the pipelined CPU.
//   MDOP_*     : MDU opcodes carried on emdop (9..15 decode as none)
//   mdstate_t  : state encodings for the multiply/divide unit FSM
package pipe_pkg;

   localparam logic [3:0] MDOP_NONE  = 4'd0;
   localparam logic [3:0] MDOP_MULT  = 4'd1;
   localparam logic [3:0] MDOP_MULTU = 4'd2;
   localparam logic [3:0] MDOP_DIV   = 4'd3;
   localparam logic [3:0] MDOP_DIVU  = 4'd4;
   localparam logic [3:0] MDOP_MFHI  = 4'd5;
   localparam logic [3:0] MDOP_MFLO  = 4'd6;
   localparam logic [3:0] MDOP_MTHI  = 4'd7;
   localparam logic [3:0] MDOP_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_FIX  = 2'd3
   } mdstate_t;

endpackage

// File: rtl/pipemdu_sign.sv
// pipemdu_sign: combinational sign helper for the MDU.
//   a, b, sgn   : operands and signed-op flag -> amag, bmag magnitudes
//   v, wide     : raw result; wide=1 negates all 64 bits (product),
//   nhi, nlo      wide=0 negates each 32-bit half independently (rem/quot)
//   vout        : sign-corrected result
module pipemdu_sign (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sgn,
   input  logic [63:0] v,
   input  logic        wide,
   input  logic        nhi,
   input  logic        nlo,
   output logic [31:0] amag,
   output logic [31:0] bmag,
   output logic [63:0] vout
);

   assign amag = (sgn & a[31]) ? (32'd0 - a) : a;
   assign bmag = (sgn & b[31]) ? (32'd0 - b) : b;

   always_comb begin
      vout = v;
      if (wide) begin
         if (nlo) vout = 64'd0 - v;
      end else begin
         if (nhi) vout[63:32] = 32'd0 - v[63:32];
         if (nlo) vout[31:0]  = 32'd0 - v[31:0];
      end
   end

endmodule

// File: rtl/pipemdu.sv
// pipemdu: iterative multiply/divide unit in the EXE stage, owns HI/LO.
//   clk, rst  : clock, synchronous active-high reset
//   ea, eb    : EXE operands (rs, rt)
//   emdop     : MDU opcode (pipe_pkg MDOP_*)
//   ecancel   : EXE instruction flushed; suppresses issue, writes and stall
//   mdres     : HI for mfhi, LO otherwise (combinational)
//   mdstall   : freeze front of pipe while an MDU op waits on a busy unit
//   mdbusy    : multiply/divide in flight
module pipemdu
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ea,
   input  logic [31:0] eb,
   input  logic [3:0]  emdop,
   input  logic        ecancel,
   output logic [31:0] mdres,
   output logic        mdstall,
   output logic        mdbusy
);

   mdstate_t    state, nstate;
   logic [4:0]  cnt;
   logic [31:0] hi, lo;
   logic [63:0] w;       // mul: {partial hi, multiplier}; div: {rem, quotient}
   logic [31:0] wd;      // multiplicand or divisor magnitude
   logic        ismul, nq, nr;

   logic        isarith, isany, isdiv, sgnop, dz, issue;
   logic [31:0] amag, bmag;
   logic [63:0] fixv, mul_nxt, div_nxt;
   logic [32:0] msum, drem, dsub;
   logic        dge;

   assign isarith = (emdop >= MDOP_MULT) && (emdop <= MDOP_DIVU);
   assign isany   = (emdop >= MDOP_MULT) && (emdop <= MDOP_MTLO);
   assign isdiv   = (emdop == MDOP_DIV) || (emdop == MDOP_DIVU);
   assign sgnop   = (emdop == MDOP_MULT) || (emdop == MDOP_DIV);
   assign dz      = (eb == 32'd0);

   assign mdbusy  = (state != MD_IDLE);
   assign mdstall = ~ecancel & mdbusy & isany;
   assign issue   = ~ecancel & ~mdbusy & isarith;
   assign mdres   = (emdop == MDOP_MFHI) ? hi : lo;

   pipemdu_sign u_sign (
      .a(ea), .b(eb), .sgn(sgnop),
      .v(w), .wide(ismul), .nhi(nr), .nlo(nq),
      .amag(amag), .bmag(bmag), .vout(fixv)
   );

   // shift-add: add multiplicand into the upper half when the multiplier lsb is set
   assign msum    = {1'b0, w[63:32]} + (w[0] ? {1'b0, wd} : 33'd0);
   assign mul_nxt = {msum, w[31:1]};

   // restoring divide: shift next dividend bit into the remainder, subtract if it fits
   assign drem    = {w[63:32], w[31]};
   assign dge     = (drem >= {1'b0, wd});
   assign dsub    = drem - {1'b0, wd};
   assign div_nxt = {dge ? dsub[31:0] : drem[31:0], w[30:0], dge};

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         MD_IDLE: if (issue) nstate = isdiv ? MD_DIV : MD_MUL;
         MD_MUL,
         MD_DIV:  if (cnt == 5'd31) nstate = MD_FIX;
         MD_FIX:  nstate = MD_IDLE;
         default: nstate = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 5'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         w     <= 64'd0;
         wd    <= 32'd0;
         ismul <= 1'b0;
         nq    <= 1'b0;
         nr    <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (issue) begin
                  cnt   <= 5'd0;
                  ismul <= ~isdiv;
                  if (isdiv) begin
                     // divide by zero keeps the raw dividend so the
                     // iteration leaves HI=ea, LO=all ones, no fixup
                     w  <= {32'd0, dz ? ea : amag};
                     wd <= bmag;
                     nq <= ~dz & sgnop & (ea[31] ^ eb[31]);
                     nr <= ~dz & sgnop & ea[31];
                  end else begin
                     w  <= {32'd0, bmag};
                     wd <= amag;
                     nq <= sgnop & (ea[31] ^ eb[31]);
                     nr <= 1'b0;
                  end
               end
               if (~ecancel && emdop == MDOP_MTHI) hi <= ea;
               if (~ecancel && emdop == MDOP_MTLO) lo <= ea;
            end
            MD_MUL: begin
               w   <= mul_nxt;
               cnt <= cnt + 5'd1;
            end
            MD_DIV: begin
               w   <= div_nxt;
               cnt <= cnt + 5'd1;
            end
            MD_FIX: begin
               hi <= fixv[63:32];
               lo <= fixv[31:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipemdu.sv
module tb_pipemdu;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ea = 32'd0, eb = 32'd0;
   logic [3:0]  emdop = 4'd0;
   logic        ecancel = 1'b0;
   logic [31:0] mdres;
   logic        mdstall, mdbusy;

   int ntests = 0;
   int nfail  = 0;
   int n;

   pipemdu dut (
      .clk(clk), .rst(rst), .ea(ea), .eb(eb), .emdop(emdop),
      .ecancel(ecancel), .mdres(mdres), .mdstall(mdstall), .mdbusy(mdbusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // step into the next cycle: inputs change just after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
      emdop = op; ea = a; eb = b; ecancel = c;
      #1;
   endtask

   // count cycles with mdstall high, bounded
   task automatic wait_stall(output int cnt);
      cnt = 0;
      while (mdstall && cnt < 40) begin
         cnt++;
         @(posedge clk);
         #2;
      end
   endtask

   // issue an op, then wait on mflo and check both halves
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exhi, input logic [31:0] exlo);
      int s;
      drive(op, a, b, 1'b0);
      cyc();
      drive(MDOP_MFLO, 0, 0, 1'b0);
      wait_stall(s);
      chk({tag, "_stall"}, s, 33);
      chk({tag, "_lo"}, mdres, exlo);
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk({tag, "_hi"}, mdres, exhi);
      cyc();
   endtask

   initial begin
      // reset
      drive(MDOP_NONE, 0, 0, 1'b0);
      cyc(); cyc();
      rst = 1'b0;
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("rst_busy", mdbusy, 0);
      chk("rst_stall", mdstall, 0);
      chk("rst_hi", mdres, 0);
      cyc();

      // mult -2*3 with dependent mflo
      drive(MDOP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
      chk("mult_issue_stall", mdstall, 0);
      cyc();
      drive(MDOP_MFLO, 0, 0, 1'b0);
      chk("mult_busy", mdbusy, 1);
      wait_stall(n);
      chk("mult_stall_cycles", n, 33);
      chk("mult_done_busy", mdbusy, 0);
      chk("mult_lo", mdres, 32'hFFFFFFFA);
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("mult_hi", mdres, 32'hFFFFFFFF);
      cyc();

      run_op("multu", MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("div_m7_2", MDOP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_7_0", MDOP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
      run_op("div_m5_0", MDOP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
      run_op("div_ovf", MDOP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
      run_op("divu_100_7", MDOP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      // mthi while idle
      drive(MDOP_MTHI, 32'h12345678, 0, 1'b0);
      chk("mthi_idle_stall", mdstall, 0);
      cyc();
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("mfhi_idle_stall", mdstall, 0);
      chk("mfhi_idle", mdres, 32'h12345678);
      cyc();

      // mthi 5 cycles into a mult waits, then overwrites HI
      drive(MDOP_MULT, 32'd2, 32'd3, 1'b0);
      cyc();
      drive(MDOP_NONE, 0, 0, 1'b0);
      repeat (4) cyc();
      drive(MDOP_MTHI, 32'hAA, 0, 1'b0);
      wait_stall(n);
      chk("mthi_busy_stall", n, 29);
      cyc();
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("mthi_after_mult_hi", mdres, 32'hAA);
      drive(MDOP_MFLO, 0, 0, 1'b0);
      chk("mthi_after_mult_lo", mdres, 32'd6);
      cyc();

      // cancelled mult has no effect
      drive(MDOP_MULT, 32'd5, 32'd5, 1'b1);
      chk("cancel_mult_stall", mdstall, 0);
      cyc();
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("cancel_mult_busy", mdbusy, 0);
      chk("cancel_mult_hi", mdres, 32'hAA);
      drive(MDOP_MFLO, 0, 0, 1'b0);
      chk("cancel_mult_lo", mdres, 32'd6);
      cyc();

      // cancel a stalled mflo; in-flight mult still completes
      drive(MDOP_MULT, 32'd4, 32'd4, 1'b0);
      cyc();
      drive(MDOP_MFLO, 0, 0, 1'b0);
      chk("cstall_pre", mdstall, 1);
      cyc();
      drive(MDOP_MFLO, 0, 0, 1'b1);
      chk("cstall_cancel", mdstall, 0);
      chk("cstall_busy", mdbusy, 1);
      cyc();
      drive(MDOP_MFLO, 0, 0, 1'b0);
      wait_stall(n);
      chk("cstall_rest", n, 31);
      chk("cstall_lo", mdres, 32'h10);
      cyc();

      // reset during iteration 10 of a divide
      drive(MDOP_DIVU, 32'd100, 32'd7, 1'b0);
      cyc();
      drive(MDOP_NONE, 0, 0, 1'b0);
      repeat (9) cyc();
      chk("rdiv_busy_pre", mdbusy, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      drive(MDOP_MFLO, 0, 0, 1'b0);
      chk("rdiv_busy", mdbusy, 0);
      chk("rdiv_stall", mdstall, 0);
      chk("rdiv_lo", mdres, 0);
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("rdiv_hi", mdres, 0);
      drive(MDOP_NONE, 0, 0, 1'b0);
      repeat (40) cyc();
      drive(MDOP_MFLO, 0, 0, 1'b0);
      chk("rdiv_late_busy", mdbusy, 0);
      chk("rdiv_late_lo", mdres, 0);
      drive(MDOP_MFHI, 0, 0, 1'b0);
      chk("rdiv_late_hi", mdres, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/pipemdu.md
# pipemdu

Multiply/divide unit of the pipelined CPU, in the EXE stage directly downstream of the ID/EXE pipeline register. It takes the EXE-stage operands and an MDU opcode and runs MIPS mult/multu/div/divu iteratively in the background, one bit per cycle, while younger ALU instructions keep flowing. It owns the HI/LO architectural registers and serves mfhi/mflo/mthi/mtlo. It raises a stall to freeze the front of the pipeline when an instruction needs the unit while it is busy.

## Interface
- Parameters: none; the datapath is fixed at 32 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ea  in  32  EXE operand A (rs): dividend or multiplicand; source for mthi/mtlo.
- eb  in  32  EXE operand B (rt): divisor or multiplier.
- emdop  in  4  MDU opcode:
  - 0 none
  - 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo
  - 7 mthi, 8 mtlo
  - 9–15 treated as none.
- ecancel  in  1  EXE instruction is being cancelled (interrupt or exception flush); it must have no side effects.
- mdres  out  32  combinational read data: HI for mfhi, LO otherwise. Valid in a cycle where mdstall=0.
- mdstall  out  1  combinational stall request:
  - When high, hold PC, IF/ID and ID/EXE.
  - Inject a bubble into EXE/MEM.
- mdbusy  out  1  registered; an iterative operation is in flight.

## Operation
- State machine states:
  - IDLE
  - MUL: 32 iterations, shift-add on operand magnitudes.
  - DIV: 32 iterations, restoring division on magnitudes.
  - FIX: one cycle; applies sign correction, writes HI/LO, returns to IDLE.
- A 5-bit iteration counter advances in MUL and DIV. When it wraps from 31 to 0, the state moves to FIX.
- Issue: when emdop is 1–4, mdstall=0 and ecancel=0, the operands are latched into working registers.
  - Signed ops latch the magnitudes plus the result-sign bits.
  - The state moves to MUL or DIV.
- Multiply results:
  - mult: {HI,LO} = 64-bit two's-complement product.
  - multu: unsigned product.
- Divide results:
  - The quotient is truncated toward zero and goes to LO.
  - The remainder takes the sign of the dividend and goes to HI.
- Divide by zero (div and divu): LO=32'hFFFFFFFF, HI=ea. No sign fixup is applied.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: write HI or LO at the end of the issue cycle.
- mdstall = ~ecancel & mdbusy & (emdop in 1..8). Every MDU instruction waits while the unit is busy, which gives these ordering rules:
  - A new mult/div starts only after the previous one completes.
  - mthi/mtlo lands after the in-flight result and overwrites it.
- ecancel=1 has priority over everything else:
  - no issue;
  - no HI/LO write;
  - mdstall=0.
  - An operation already in flight is older than the cancelled instruction and completes normally.

## Timing
- Issue in cycle N:
  - mdbusy is high in cycles N+1 through N+33: 32 iteration cycles plus FIX.
  - HI/LO update at the edge ending N+33.
  - mdbusy falls in N+34.
- A dependent mfhi/mflo issued in N+1 stalls for 33 cycles. mdres is valid in N+34.
- mfhi/mflo with the unit idle: no stall, mdres is valid in the same cycle.
- Back-to-back mult in N and N+1: the second one stalls until N+34 and issues in that cycle.
- Reset values, taking effect at the first edge with rst=1, including mid-operation:
  - state IDLE, counter 0;
  - HI=LO=0, working registers 0;
  - mdbusy=0, so mdstall=0 and mdres=0.
  - Any in-flight operation is aborted.

## Structure
- Shared package pipe_pkg holds:
  - MDOP_* opcode constants (0–8);
  - MDU state encodings (IDLE, MUL, DIV, FIX).
- One natural sub-module: pipemdu_sign, a combinational helper for magnitude extraction and conditional 32/64-bit negation, used at issue and at FIX.
- Everything else, including the FSM, counter, HI/LO and iteration datapath, lives in pipemdu.

## Test plan
- mult ea=0xFFFFFFFE, eb=3 in cycle N; mflo in N+1:
  - mdstall high for 33 cycles;
  - in N+34, mdres=0xFFFFFFFA and HI=0xFFFFFFFF.
- multu ea=0xFFFFFFFF, eb=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Divide cases:
  - div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 → LO=0xFFFFFFFF, HI=7.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x12345678 while idle, then mfhi → no stall, mdres=0x12345678.
- mthi 0xAA issued 5 cycles into a mult → stalls until the mult completes, then HI=0xAA.
- ecancel cases:
  - mult with ecancel=1 → mdbusy stays 0, HI/LO unchanged.
  - ecancel on a stalled mflo → mdstall=0 that cycle, and the in-flight op still completes.
- rst pulsed in iteration 10 of a div → next cycle mdbusy=0, HI=LO=0, mdstall=0; no stale write-back afterwards.
